// File: rtl/preamble_detect_ctrl_if.sv
// Bus bundle between the preamble detect controller and its environment.
// The stat_* members exist only when DETECT_STATS_EN is defined.
interface preamble_detect_ctrl_if #(
  parameter int LENGTH      = 64,
  parameter int BANKS       = 16,
  parameter int PEAK_WINDOW = 16,
  parameter int TIMEOUT_W   = 16
);
  localparam int CORR_WIDTH = $clog2(LENGTH + 1);
  localparam int BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int OFF_W      = $clog2(PEAK_WINDOW + 1);

  logic                        arm;
  logic [CORR_WIDTH-1:0]       threshold;
  logic [TIMEOUT_W-1:0]        timeout_len;
  logic [CORR_WIDTH*BANKS-1:0] corr_dat;
  logic                        corr_vld;
  logic                        all_zeros;
  logic                        corr_rst;
  logic                        busy;
  logic                        det_vld;
  logic [BANK_W-1:0]           det_bank;
  logic [CORR_WIDTH-1:0]       det_score;
  logic [OFF_W-1:0]            det_offset;
  logic                        timeout;
`ifdef DETECT_STATS_EN
  logic                        stat_clr;
  logic [15:0]                 stat_det;
  logic [15:0]                 stat_to;
`endif

  modport master (
    input  arm, threshold, timeout_len, corr_dat, corr_vld, all_zeros,
`ifdef DETECT_STATS_EN
    input  stat_clr,
    output stat_det, stat_to,
`endif
    output corr_rst, busy, det_vld, det_bank, det_score, det_offset, timeout
  );

  modport slave (
    output arm, threshold, timeout_len, corr_dat, corr_vld, all_zeros,
`ifdef DETECT_STATS_EN
    output stat_clr,
    input  stat_det, stat_to,
`endif
    input  corr_rst, busy, det_vld, det_bank, det_score, det_offset, timeout
  );
endinterface

// File: rtl/preamble_detect_ctrl.sv
// Preamble detect controller: arms the banked correlator, waits for a quiet line and
// tracks the best-scoring bank. Define DETECT_STATS_EN for saturating pulse counters.
module preamble_detect_ctrl #(
  parameter int LENGTH       = 64,
  parameter int BANKS        = 16,
  parameter int QUIET_CYCLES = 8,
  parameter int PEAK_WINDOW  = 16,
  parameter int TIMEOUT_W    = 16
) (
  input logic                    clk,
  input logic                    rst,
  preamble_detect_ctrl_if.master bus
);
  localparam int CORR_WIDTH = $clog2(LENGTH + 1);
  localparam int BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int OFF_W      = $clog2(PEAK_WINDOW + 1);
  localparam int QCNT_W     = $clog2(QUIET_CYCLES + 1);
  localparam logic [QCNT_W-1:0] QUIET_LIM = QCNT_W'(QUIET_CYCLES);
  localparam logic [OFF_W-1:0]  WIN_LIM   = OFF_W'(PEAK_WINDOW);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUIET  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_TRACK  = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [QCNT_W-1:0]     qcnt_r, qcnt_next_s, qcnt_inc_s;
  logic [TIMEOUT_W-1:0]  tcnt_r, tcnt_next_s, tcnt_inc_s;
  logic [OFF_W-1:0]      wcnt_r, wcnt_next_s, wcnt_inc_s;
  logic [BANK_W-1:0]     best_bank_r, best_bank_next_s, max_bank_s;
  logic [CORR_WIDTH-1:0] best_score_r, best_score_next_s, max_score_s;
  logic                  det_fire_s, to_fire_s;
  logic                  corr_rst_r, busy_r, det_vld_r, timeout_r;
  logic [BANK_W-1:0]     det_bank_r;
  logic [CORR_WIDTH-1:0] det_score_r;
  logic [OFF_W-1:0]      det_offset_r;

  assign qcnt_inc_s = (qcnt_r == QUIET_LIM) ? qcnt_r : qcnt_r + QCNT_W'(1'b1);
  assign tcnt_inc_s = (tcnt_r == {TIMEOUT_W{1'b1}}) ? tcnt_r : tcnt_r + TIMEOUT_W'(1'b1);
  assign wcnt_inc_s = (wcnt_r == WIN_LIM) ? wcnt_r : wcnt_r + OFF_W'(1'b1);

  // Max across banks; strict compare keeps the lowest index on ties
  always_comb begin
    max_score_s = '0;
    max_bank_s  = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (bus.corr_dat[i*CORR_WIDTH +: CORR_WIDTH] > max_score_s) begin
        max_score_s = bus.corr_dat[i*CORR_WIDTH +: CORR_WIDTH];
        max_bank_s  = BANK_W'(i);
      end else begin
        max_score_s = max_score_s;
      end
    end
  end

  // Next-state, counter and decision logic; arm overrides the state but not a decision
  always_comb begin
    state_next_s      = state_r;
    qcnt_next_s       = qcnt_r;
    tcnt_next_s       = tcnt_r;
    wcnt_next_s       = wcnt_r;
    best_bank_next_s  = best_bank_r;
    best_score_next_s = best_score_r;
    det_fire_s        = 1'b0;
    to_fire_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_IDLE;
      end
      ST_QUIET: begin
        if (bus.corr_vld) begin
          if (bus.all_zeros) begin
            qcnt_next_s = qcnt_inc_s;
            if (qcnt_inc_s == QUIET_LIM) begin
              state_next_s = ST_SEARCH;
              tcnt_next_s  = '0;
            end else begin
              state_next_s = ST_QUIET;
            end
          end else begin
            qcnt_next_s = '0;
          end
        end else begin
          qcnt_next_s = qcnt_r;
        end
      end
      ST_SEARCH: begin
        if (bus.corr_vld) begin
          if (max_score_s >= bus.threshold) begin
            state_next_s      = ST_TRACK;
            best_bank_next_s  = max_bank_s;
            best_score_next_s = max_score_s;
            wcnt_next_s       = '0;
          end else begin
            tcnt_next_s = tcnt_inc_s;
            if ((bus.timeout_len != '0) && (tcnt_inc_s == bus.timeout_len)) begin
              to_fire_s    = 1'b1;
              state_next_s = ST_IDLE;
            end else begin
              state_next_s = ST_SEARCH;
            end
          end
        end else begin
          tcnt_next_s = tcnt_r;
        end
      end
      ST_TRACK: begin
        if (bus.corr_vld) begin
          if (max_score_s > best_score_r) begin
            best_bank_next_s  = max_bank_s;
            best_score_next_s = max_score_s;
            wcnt_next_s       = '0;
          end else begin
            wcnt_next_s = wcnt_inc_s;
            if (wcnt_inc_s == WIN_LIM) begin
              det_fire_s   = 1'b1;
              state_next_s = ST_IDLE;
            end else begin
              state_next_s = ST_TRACK;
            end
          end
        end else begin
          wcnt_next_s = wcnt_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (bus.arm) begin
      state_next_s      = ST_QUIET;
      qcnt_next_s       = '0;
      tcnt_next_s       = '0;
      wcnt_next_s       = '0;
      best_bank_next_s  = '0;
      best_score_next_s = '0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      qcnt_r       <= '0;
      tcnt_r       <= '0;
      wcnt_r       <= '0;
      best_bank_r  <= '0;
      best_score_r <= '0;
      corr_rst_r   <= 1'b0;
      busy_r       <= 1'b0;
      det_vld_r    <= 1'b0;
      timeout_r    <= 1'b0;
      det_bank_r   <= '0;
      det_score_r  <= '0;
      det_offset_r <= '0;
    end else begin
      state_r      <= state_next_s;
      qcnt_r       <= qcnt_next_s;
      tcnt_r       <= tcnt_next_s;
      wcnt_r       <= wcnt_next_s;
      best_bank_r  <= best_bank_next_s;
      best_score_r <= best_score_next_s;
      corr_rst_r   <= bus.arm;
      busy_r       <= (state_next_s != ST_IDLE);
      det_vld_r    <= det_fire_s;
      timeout_r    <= to_fire_s;
      if (det_fire_s) begin
        det_bank_r   <= best_bank_r;
        det_score_r  <= best_score_r;
        det_offset_r <= wcnt_inc_s;
      end
    end
  end

  assign bus.corr_rst   = corr_rst_r;
  assign bus.busy       = busy_r;
  assign bus.det_vld    = det_vld_r;
  assign bus.det_bank   = det_bank_r;
  assign bus.det_score  = det_score_r;
  assign bus.det_offset = det_offset_r;
  assign bus.timeout    = timeout_r;

`ifdef DETECT_STATS_EN
  logic [15:0] stat_det_r, stat_to_r;

  // Saturating pulse counters; stat_clr takes priority over a coincident pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_det_r <= 16'h0000;
      stat_to_r  <= 16'h0000;
    end else if (bus.stat_clr) begin
      stat_det_r <= 16'h0000;
      stat_to_r  <= 16'h0000;
    end else begin
      if (det_vld_r && (stat_det_r != 16'hFFFF)) stat_det_r <= stat_det_r + 16'd1;
      if (timeout_r && (stat_to_r != 16'hFFFF))  stat_to_r  <= stat_to_r + 16'd1;
    end
  end

  assign bus.stat_det = stat_det_r;
  assign bus.stat_to  = stat_to_r;
`endif
endmodule

// File: tb/tb_preamble_detect_ctrl.sv
// Bench for preamble_detect_ctrl: directed scenarios plus randomized runs, each
// predicted by a sequence-level model that scans the sample list since arm.
module tb_preamble_detect_ctrl;
  localparam int LENGTH = 64, BANKS = 16, QUIET_CYCLES = 8, PEAK_WINDOW = 16, TIMEOUT_W = 16;
  localparam int CW = $clog2(LENGTH + 1);
  localparam int DW = CW * BANKS;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0, checks = 0;
  int   exp_kind, exp_idx, exp_bank, exp_score, exp_off;
  int   exp_det_cnt = 0, exp_to_cnt = 0;
  logic [DW-1:0] dat_q[$];
  bit            az_q[$];

  preamble_detect_ctrl_if #(.LENGTH(LENGTH), .BANKS(BANKS), .PEAK_WINDOW(PEAK_WINDOW),
                            .TIMEOUT_W(TIMEOUT_W)) bus_if ();
  preamble_detect_ctrl #(.LENGTH(LENGTH), .BANKS(BANKS), .QUIET_CYCLES(QUIET_CYCLES),
                         .PEAK_WINDOW(PEAK_WINDOW), .TIMEOUT_W(TIMEOUT_W))
    dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int ba, input int sa, input int bb, input int sb, input int base);
    logic [DW-1:0] d;
    for (int j = 0; j < BANKS; j++) d[j*CW +: CW] = CW'(base);
    d[ba*CW +: CW] = CW'(sa);
    d[bb*CW +: CW] = CW'(sb);
    return d;
  endfunction

  task automatic fill(input logic [DW-1:0] d, input bit az, input int n);
    for (int i = 0; i < n; i++) begin
      dat_q.push_back(d);
      az_q.push_back(az);
    end
  endtask

  task automatic clear_seq();
    dat_q.delete();
    az_q.delete();
  endtask

  function automatic int max_of(input logic [DW-1:0] d, output int bank);
    int best;
    best = -1;
    bank = 0;
    for (int b = 0; b < BANKS; b++) begin
      if (int'(d[b*CW +: CW]) > best) begin
        best = int'(d[b*CW +: CW]);
        bank = b;
      end
    end
    return best;
  endfunction

  // Outcome of the sample list: kind 0 none, 1 detection, 2 timeout, at sample exp_idx
  task automatic predict(input int thr, input int tlen);
    int run = 0, start = -1, first = -1, bank, sc, last, cnt;
    exp_kind = 0; exp_idx = -1; exp_bank = 0; exp_score = 0; exp_off = 0;
    for (int i = 0; i < dat_q.size(); i++) begin
      run = az_q[i] ? run + 1 : 0;
      if (run == QUIET_CYCLES) begin start = i + 1; break; end
    end
    if (start < 0) return;
    for (int i = start; i < dat_q.size(); i++) begin
      sc = max_of(dat_q[i], bank);
      if (sc >= thr) begin first = i; break; end
    end
    cnt = (first < 0) ? dat_q.size() - start : first - start;
    if (tlen != 0 && cnt >= tlen) begin
      exp_kind = 2; exp_idx = start + tlen - 1;
      return;
    end
    if (first < 0) return;
    exp_score = max_of(dat_q[first], exp_bank);
    last = first;
    for (int i = first + 1; i < dat_q.size(); i++) begin
      sc = max_of(dat_q[i], bank);
      if (sc > exp_score) begin
        exp_score = sc; exp_bank = bank; last = i;
      end else if (i - last == PEAK_WINDOW) begin
        exp_kind = 1; exp_idx = i; exp_off = PEAK_WINDOW;
        return;
      end
    end
  endtask

  task automatic run_seq(input string tag, input int thr, input int tlen, input int gap_pct,
                         input int stop_at, input bit skip_arm, input bit arm_at_end);
    int lim;
    logic [DW-1:0] junk;
    bus_if.threshold   = CW'(thr);
    bus_if.timeout_len = TIMEOUT_W'(tlen);
    predict(thr, tlen);
    if (!skip_arm) begin
      bus_if.arm = 1'b1; bus_if.corr_vld = 1'b0;
      tick();
      check({tag, " arm corr_rst"}, bus_if.corr_rst, 1);
      check({tag, " arm busy"}, bus_if.busy, 1);
      check({tag, " arm det_vld"}, bus_if.det_vld, 0);
      check({tag, " arm timeout"}, bus_if.timeout, 0);
      bus_if.arm = 1'b0;
      tick();
      check({tag, " corr_rst end"}, bus_if.corr_rst, 0);
    end
    lim = (stop_at >= 0 && stop_at < dat_q.size()) ? stop_at : dat_q.size();
    for (int k = 0; k < lim; k++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          for (int j = 0; j < BANKS; j++) junk[j*CW +: CW] = CW'($urandom_range(0, LENGTH));
          bus_if.corr_vld = 1'b0; bus_if.corr_dat = junk; bus_if.all_zeros = 1'b0;
          tick();
          check({tag, " gap det_vld"}, bus_if.det_vld, 0);
        end
      end
      bus_if.corr_vld = 1'b1; bus_if.corr_dat = dat_q[k]; bus_if.all_zeros = az_q[k];
      bus_if.arm = arm_at_end && (k == exp_idx);
      tick();
      bus_if.arm = 1'b0; bus_if.corr_vld = 1'b0;
      check({tag, " det_vld"}, bus_if.det_vld, (exp_kind == 1) && (k == exp_idx));
      check({tag, " timeout"}, bus_if.timeout, (exp_kind == 2) && (k == exp_idx));
      if (k == exp_idx) begin
        if (exp_kind == 1) begin
          exp_det_cnt++;
          check({tag, " det_bank"}, bus_if.det_bank, exp_bank);
          check({tag, " det_score"}, bus_if.det_score, exp_score);
          check({tag, " det_offset"}, bus_if.det_offset, exp_off);
        end else begin
          exp_to_cnt++;
        end
        check({tag, " busy after"}, bus_if.busy, arm_at_end);
        check({tag, " corr_rst after"}, bus_if.corr_rst, arm_at_end);
        break;
      end else begin
        check({tag, " busy"}, bus_if.busy, 1);
      end
    end
  endtask

  task automatic seq_t1();
    clear_seq();
    fill(mk(0, 0, 0, 0, 0), 1'b1, 8);
    fill(mk(5, 40, 5, 40, 10), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 16);
  endtask

  task automatic seq_t2();
    clear_seq();
    fill(mk(0, 0, 0, 0, 0), 1'b1, 8);
    fill(mk(5, 40, 5, 40, 10), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 3);
    fill(mk(3, 44, 3, 44, 10), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 16);
  endtask

  task automatic gen_random(input int thr);
    logic [DW-1:0] d;
    int b, hi;
    clear_seq();
    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < BANKS; j++) d[j*CW +: CW] = CW'($urandom_range(0, thr - 1));
      if ($urandom_range(0, 99) < 8) begin
        b  = $urandom_range(0, BANKS - 1);
        hi = $urandom_range(thr, LENGTH);
        d[b*CW +: CW] = CW'(hi);
        if ($urandom_range(0, 2) == 0) begin
          b = $urandom_range(0, BANKS - 1);
          d[b*CW +: CW] = CW'(hi);
        end
      end
      fill(d, $urandom_range(0, 9) != 0, 1);
    end
  endtask

  initial begin
    int thr, tlen, stop;
    rst = 1'b1;
    bus_if.arm = 1'b0; bus_if.threshold = '0; bus_if.timeout_len = '0;
    bus_if.corr_dat = '0; bus_if.corr_vld = 1'b0; bus_if.all_zeros = 1'b0;
`ifdef DETECT_STATS_EN
    bus_if.stat_clr = 1'b0;
`endif
    tick(); tick();
    check("reset busy", bus_if.busy, 0);
    check("reset det_vld", bus_if.det_vld, 0);
    check("reset corr_rst", bus_if.corr_rst, 0);
    check("reset det_bank", bus_if.det_bank, 0);
    check("reset timeout", bus_if.timeout, 0);
    rst = 1'b0;
    tick();

    seq_t1(); run_seq("t1", 32, 0, 0, -1, 1'b0, 1'b0);
    check("t1 bank const", bus_if.det_bank, 5);
    check("t1 score const", bus_if.det_score, 40);
    check("t1 offset const", bus_if.det_offset, 16);

    seq_t2(); run_seq("t2", 32, 0, 0, -1, 1'b0, 1'b0);
    check("t2 bank const", bus_if.det_bank, 3);
    check("t2 score const", bus_if.det_score, 44);

    clear_seq();
    fill(mk(0, 0, 0, 0, 0), 1'b1, 8);
    fill(mk(2, 50, 9, 50, 10), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 16);
    run_seq("t3 tie", 32, 0, 0, -1, 1'b0, 1'b0);
    check("t3 bank const", bus_if.det_bank, 2);

    clear_seq();
    fill(mk(0, 0, 0, 0, 0), 1'b1, 8);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 2);
    fill(mk(7, 33, 7, 33, 10), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 16);
    run_seq("expiry cross", 32, 3, 0, -1, 1'b0, 1'b0);
    check("expiry bank const", bus_if.det_bank, 7);

    clear_seq();
    fill(mk(0, 0, 0, 0, 0), 1'b1, 8);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 110);
    run_seq("t4 timeout", 32, 100, 0, -1, 1'b0, 1'b0);
    check("t4 timeout idx", exp_idx, 107);
    bus_if.corr_vld = 1'b1; tick(); tick(); bus_if.corr_vld = 1'b0;
    check("t4 idle busy", bus_if.busy, 0);
    check("t4 idle timeout", bus_if.timeout, 0);
    check("t4 idle det_vld", bus_if.det_vld, 0);

    clear_seq();
    fill(mk(0, 60, 0, 60, 0), 1'b1, 6);
    fill(mk(0, 60, 0, 60, 0), 1'b0, 1);
    fill(mk(0, 60, 0, 60, 0), 1'b1, 8);
    fill(mk(0, 60, 0, 60, 0), 1'b0, 1);
    fill(mk(0, 20, 0, 20, 20), 1'b0, 16);
    run_seq("t5 quiet", 32, 0, 40, -1, 1'b0, 1'b0);
    check("t5 bank const", bus_if.det_bank, 0);
    check("t5 score const", bus_if.det_score, 60);

    seq_t1(); run_seq("t6 partial", 32, 0, 0, 12, 1'b0, 1'b0);
    seq_t1(); run_seq("t6 rearm", 32, 0, 0, -1, 1'b0, 1'b0);
    seq_t2(); run_seq("t6 arm at det", 32, 0, 0, -1, 1'b0, 1'b1);
    seq_t1(); run_seq("t6 after", 32, 0, 0, -1, 1'b1, 1'b0);
    check("held bank before rst", bus_if.det_bank, 5);
    seq_t2(); run_seq("t6 rst partial", 32, 0, 0, 10, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("async rst busy", bus_if.busy, 0);
    check("async rst det_bank", bus_if.det_bank, 0);
    check("async rst det_score", bus_if.det_score, 0);
    check("async rst det_offset", bus_if.det_offset, 0);
    check("async rst det_vld", bus_if.det_vld, 0);
    exp_det_cnt = 0; exp_to_cnt = 0;
    tick();
    rst = 1'b0;
    bus_if.corr_vld = 1'b1; bus_if.all_zeros = 1'b1; bus_if.corr_dat = mk(0, 60, 0, 60, 60);
    repeat (12) tick();
    bus_if.corr_vld = 1'b0;
    check("post rst idle busy", bus_if.busy, 0);
    check("post rst idle det_vld", bus_if.det_vld, 0);

    for (int r = 0; r < 25; r++) begin
      thr  = $urandom_range(20, 60);
      tlen = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(5, 60);
      stop = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 60) : -1;
      gen_random(thr);
      run_seq($sformatf("rand%0d", r), thr, tlen, 20, stop, 1'b0, 1'b0);
    end
    tick(); tick();

`ifdef DETECT_STATS_EN
    check("stat_det count", bus_if.stat_det, exp_det_cnt);
    check("stat_to count", bus_if.stat_to, exp_to_cnt);
    bus_if.stat_clr = 1'b1; tick(); bus_if.stat_clr = 1'b0;
    check("stat_det clr", bus_if.stat_det, 0);
    check("stat_to clr", bus_if.stat_to, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
